// File: rtl/cache_fill_ctrl.sv
// Cache-miss block fill controller: pipelined per-word reads with back-pressure, in-order returns.
// Define CACHE_FILL_CWF_EN for critical-word-first ordering and the critical_word_ready output.
module cache_fill_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     memory_ready,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     memory_enable,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] word_index,
  output logic                     write_tag_array,
  output logic                     fill_done
`ifdef CACHE_FILL_CWF_EN
  ,
  output logic                     critical_word_ready
`endif
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned BLK_W = IDX_W + OFF_W;
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BlkMask = ADDR_W'((64'd1 << BLK_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LastCnt = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   ret_idx;
  logic               ret_fire;

  // Word indices wrap inside the block; the tag bits of base_q are never touched.
  assign issue_idx = start_q + issue_cnt_q[IDX_W-1:0];
  assign ret_idx   = start_q + ret_cnt_q[IDX_W-1:0];
  assign ret_fire  = memory_data_valid && (state_q != StIdle) && (ret_cnt_q <= LastCnt);

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    start_d          = start_q;
    issue_cnt_d      = issue_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    done_d           = 1'b0;
    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (miss_detected) begin
          state_d     = StIssue;
          base_d      = miss_address & ~BlkMask;
`ifdef CACHE_FILL_CWF_EN
          start_d     = miss_address[BLK_W-1:OFF_W];
`else
          start_d     = '0;
`endif
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
        end
      end
      StIssue: begin
        fsm_busy       = 1'b1;
        memory_enable  = 1'b1;
        memory_address = base_q | (ADDR_W'(issue_idx) << OFF_W);
        if (memory_ready) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LastCnt) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        fsm_busy = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The final return beat ends the fill even if it lands in the same cycle as the last accept.
    if (ret_fire) begin
      write_data_array = 1'b1;
      word_index       = ret_idx;
      ret_cnt_d        = ret_cnt_q + CNT_W'(1);
      if (ret_cnt_q == LastCnt) begin
        write_tag_array = 1'b1;
        state_d         = StIdle;
        done_d          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      start_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      done_q      <= done_d;
    end
  end

  assign fill_done = done_q;

`ifdef CACHE_FILL_CWF_EN
  assign critical_word_ready = ret_fire && (ret_cnt_q == '0);
`endif

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Parametrised cache-miss fill controller. On a miss it latches the block address, issues one memory read per word of the block (pipelined, with back-pressure), and steers returning words into the cache data array by word index. It writes the tag on the final beat and holds fsm_busy as the pipeline stall for the whole fill. Sits between the cache tag-match logic and the memory model, in place of the fixed 8-word, 16-bit fill FSM.

Parameters:
ADDR_W, 16, byte-address width.
DATA_W, 16, memory/cache word width in bits; must be a multiple of 8.
WORDS, 8, words per cache block; power of 2, at least 2.
(derived) OFF_W = log2(DATA_W/8) byte-offset bits; IDX_W = log2(WORDS) word-index bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
miss_detected  in  1  tag-match miss, level
miss_address  in  ADDR_W  byte address that missed; sampled only on accept
memory_ready  in  1  memory accepts a request this cycle
memory_data_valid  in  1  return beat valid; returns arrive in issue order
fsm_busy  out  1  fill in progress (stall)
memory_enable  out  1  read request valid
memory_address  out  ADDR_W  request byte address, low OFF_W bits zero
write_data_array  out  1  write memory_data into word word_index this cycle
word_index  out  IDX_W  target word of current return beat
write_tag_array  out  1  tag write, final beat only
fill_done  out  1  one-cycle pulse the cycle after the final beat

Behaviour:
- One clock, clk. rst_n is synchronous, active-low: when sampled low, state goes to IDLE and all counters clear. All outputs read 0 the following cycle, including mid-fill; outstanding returns after reset are ignored.
- States: IDLE, ISSUE, DRAIN.
- IDLE: fsm_busy=0 and memory_enable=0. If miss_detected=1, latch base = miss_address with the low IDX_W+OFF_W bits zeroed, clear issue_cnt and ret_cnt, and go to ISSUE. fsm_busy rises the cycle after the miss is seen.
- ISSUE: memory_enable=1 and memory_address = base + (issue_cnt << OFF_W).
  - A request is accepted when memory_enable and memory_ready are both 1; issue_cnt then increments.
  - After WORDS accepts, go to DRAIN, or straight to IDLE if all returns have already arrived.
- Returns, in ISSUE or DRAIN: memory_data_valid=1 gives write_data_array=1 and word_index = return order index, combinational in the same cycle; ret_cnt then increments.
  - On the beat where ret_cnt = WORDS-1, write_tag_array=1 in the same cycle, and the next state is IDLE.
  - fill_done=1 for one cycle after that beat.
- fsm_busy = 1 in ISSUE and DRAIN, including the final-beat cycle.
- memory_data_valid in IDLE, or beyond WORDS beats, is ignored: no write.
- miss_detected while busy is ignored. A miss on the fill_done cycle is accepted normally (state is IDLE).
- Issue and return may occur in the same cycle; the counters are independent. Minimum fill time with zero-latency memory is WORDS+1 cycles.
- Counters are IDX_W+1 bits wide. Address arithmetic wraps within the block only; the tag bits of base are never modified.

Optional Feature:
CACHE_FILL_CWF_EN (critical-word-first).
- When defined:
  - Also latch start = miss_address[IDX_W+OFF_W-1:OFF_W].
  - Issue order and word_index are (start + n) mod WORDS.
  - Add output critical_word_ready (1 bit), pulsing high with the first return beat so the pipeline may forward that word.
  - fsm_busy behaviour is unchanged.
- When undefined: start is 0, there is no critical_word_ready port, and order is 0..WORDS-1.

Test Plan:
1. Defaults; miss at 0x1236, memory_ready=1, valid 4 cycles after each request -> addresses 0x1230,0x1232,...,0x123E on consecutive cycles; word_index 0..7; write_tag_array with the index-7 beat; fill_done one cycle later; fsm_busy low after that.
2. memory_ready toggles 1,0,0,1,... -> each address is held until accepted; exactly 8 accepts, no duplicate or skipped address; 8 data writes.
3. Extra memory_data_valid pulses in IDLE and after beat 8; miss_detected held high throughout the fill -> no spurious writes; a second fill starts only from IDLE.
4. rst_n low for one cycle after 3 returns of a fill at 0xA5F0 -> next cycle all outputs 0, state IDLE; a new miss at 0x0040 then fills 0x0040..0x004E cleanly.
5. WORDS=4, DATA_W=32, miss 0x801C -> addresses 0x8010,0x8014,0x8018,0x801C; write_tag_array on beat 4.
6. CACHE_FILL_CWF_EN, defaults, miss 0x1236 -> addresses 0x1236..0x123E, then 0x1230..0x1234; word_index 3,4,5,6,7,0,1,2; critical_word_ready on the index-3 beat only.
